// File: rtl/conv_window_feeder_if.sv
// Bus bundle between the window feeder, its image/kernel memories and the
// downstream convolver. The feeder sits on the slave side.
interface conv_window_feeder_if #(
  parameter int BIT_DEPTH = 8,
  parameter int ADDR_W    = 8
);
  logic                 start;
  logic                 stride;
  logic [ADDR_W-1:0]    img_rd_addr;
  logic                 img_rd_en;
  logic [BIT_DEPTH-1:0] img_rd_data;
  logic [3:0]           k_rd_addr;
  logic                 k_rd_en;
  logic [BIT_DEPTH-1:0] k_rd_data;
  logic [BIT_DEPTH-1:0] o_kernel_data;
  logic                 o_kernel_valid;
  logic [BIT_DEPTH-1:0] o_row1_data;
  logic [BIT_DEPTH-1:0] o_row2_data;
  logic [BIT_DEPTH-1:0] o_row3_data;
  logic                 o_valid;
  logic                 o_band_start;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, stride, img_rd_data, k_rd_data,
    output img_rd_addr, img_rd_en, k_rd_addr, k_rd_en,
           o_kernel_data, o_kernel_valid,
           o_row1_data, o_row2_data, o_row3_data,
           o_valid, o_band_start, busy, done
  );

  modport master (
    output start, stride, img_rd_data, k_rd_data,
    input  img_rd_addr, img_rd_en, k_rd_addr, k_rd_en,
           o_kernel_data, o_kernel_valid,
           o_row1_data, o_row2_data, o_row3_data,
           o_valid, o_band_start, busy, done
  );
endinterface

// File: rtl/conv_window_feeder.sv
// 3-row window feeder: streams the 9 kernel coefficients, then walks the
// image band by band, emitting one 3-pixel column every 4 cycles.
module conv_window_feeder #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ADDR_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  conv_window_feeder_if.slave  bus
);
  localparam int RW = $clog2(IMG_H + 2);
  localparam int CW = $clog2(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, KERNEL, FETCH, DONE} state_t;

  state_t               state, state_nx;
  logic [3:0]           kcnt;
  logic [1:0]           phase;
  logic [RW-1:0]        r;
  logic [CW-1:0]        c;
  logic                 stride_q;
  logic                 kv_q;
  logic                 valid_q;
  logic                 band_q;
  logic [BIT_DEPTH-1:0] cap0, cap1;
  logic [BIT_DEPTH-1:0] row1_q, row2_q, row3_q;

  logic [RW-1:0]        r_next;
  logic [RW:0]          row_sel;
  logic [ADDR_W-1:0]    pix_addr;
  logic                 last_col, last_band;

  // Next band origin, and whether that band would run off the image bottom.
  assign r_next    = r + (stride_q ? RW'(2) : RW'(1));
  assign last_band = ({1'b0, r_next} + (RW+1)'(2)) > (RW+1)'(IMG_H - 1);
  assign last_col  = (c == CW'(IMG_W - 1));
  // Phase 0..2 selects rows r..r+2 of the current column.
  assign row_sel   = (RW+1)'(r) + (RW+1)'(phase);
  assign pix_addr  = ADDR_W'(row_sel) * ADDR_W'(IMG_W) + ADDR_W'(c);

  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.o_kernel_valid = kv_q;
  // Kernel memory data is valid the cycle after the read; gate it so idle
  // cycles and reset present zero.
  assign bus.o_kernel_data  = kv_q ? bus.k_rd_data : '0;
  assign bus.o_valid        = valid_q;
  assign bus.o_band_start   = band_q;
  assign bus.o_row1_data    = row1_q;
  assign bus.o_row2_data    = row2_q;
  assign bus.o_row3_data    = row3_q;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and memory read strobes.
  always_comb begin
    state_nx        = state;
    bus.img_rd_en   = 1'b0;
    bus.img_rd_addr = '0;
    bus.k_rd_en     = 1'b0;
    bus.k_rd_addr   = '0;
    case (state)
      IDLE:   if (bus.start) state_nx = KERNEL;
      KERNEL: begin
        bus.k_rd_en   = 1'b1;
        bus.k_rd_addr = kcnt;
        if (kcnt == 4'd8) state_nx = FETCH;
      end
      FETCH: begin
        if (phase != 2'd3) begin
          bus.img_rd_en   = 1'b1;
          bus.img_rd_addr = pix_addr;
        end
        if (phase == 2'd3 && last_col && last_band) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters, row captures and the output column registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      kcnt     <= '0;
      phase    <= '0;
      r        <= '0;
      c        <= '0;
      stride_q <= 1'b0;
      kv_q     <= 1'b0;
      valid_q  <= 1'b0;
      band_q   <= 1'b0;
      cap0     <= '0;
      cap1     <= '0;
      row1_q   <= '0;
      row2_q   <= '0;
      row3_q   <= '0;
    end else begin
      kv_q    <= (state == KERNEL);
      valid_q <= 1'b0;
      band_q  <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          stride_q <= bus.stride;
          r        <= '0;
          c        <= '0;
          kcnt     <= '0;
          phase    <= '0;
        end
        KERNEL: begin
          kcnt  <= kcnt + 4'd1;
          phase <= '0;
        end
        FETCH: begin
          phase <= phase + 2'd1;
          if (phase == 2'd1) cap0 <= bus.img_rd_data;
          if (phase == 2'd2) cap1 <= bus.img_rd_data;
          if (phase == 2'd3) begin
            row1_q  <= cap0;
            row2_q  <= cap1;
            row3_q  <= bus.img_rd_data;
            valid_q <= 1'b1;
            band_q  <= (c == '0);
            if (last_col) begin
              c <= '0;
              if (!last_band) r <= r_next;
            end else begin
              c <= c + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: three instances (4x4, 5x8, 3x3) share one
// clock and reset; `cur` picks which one is started and observed.
module tb_conv_window_feeder;
  logic clk = 1'b0;
  logic rst;
  logic start_d, stride_d;
  int   cur;
  int   checks, errors;

  always #5 clk = ~clk;

  conv_window_feeder_if #(.BIT_DEPTH(8), .ADDR_W(8)) if0 ();
  conv_window_feeder_if #(.BIT_DEPTH(8), .ADDR_W(8)) if1 ();
  conv_window_feeder_if #(.BIT_DEPTH(8), .ADDR_W(8)) if2 ();

  conv_window_feeder #(.BIT_DEPTH(8), .IMG_W(4), .IMG_H(4), .ADDR_W(8)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
  conv_window_feeder #(.BIT_DEPTH(8), .IMG_W(5), .IMG_H(8), .ADDR_W(8)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
  conv_window_feeder #(.BIT_DEPTH(8), .IMG_W(3), .IMG_H(3), .ADDR_W(8)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

  assign if0.start = start_d && (cur == 0);
  assign if1.start = start_d && (cur == 1);
  assign if2.start = start_d && (cur == 2);
  assign if0.stride = stride_d;
  assign if1.stride = stride_d;
  assign if2.stride = stride_d;

  // Synchronous-read memories, one read port per instance.
  logic [7:0] img_mem [256];
  logic [7:0] k_mem [16];
  logic [7:0] ird0, ird1, ird2, krd0, krd1, krd2;
  always @(posedge clk) begin
    if (if0.img_rd_en) ird0 <= img_mem[if0.img_rd_addr];
    if (if1.img_rd_en) ird1 <= img_mem[if1.img_rd_addr];
    if (if2.img_rd_en) ird2 <= img_mem[if2.img_rd_addr];
    if (if0.k_rd_en)   krd0 <= k_mem[if0.k_rd_addr];
    if (if1.k_rd_en)   krd1 <= k_mem[if1.k_rd_addr];
    if (if2.k_rd_en)   krd2 <= k_mem[if2.k_rd_addr];
  end
  assign if0.img_rd_data = ird0;
  assign if1.img_rd_data = ird1;
  assign if2.img_rd_data = ird2;
  assign if0.k_rd_data   = krd0;
  assign if1.k_rd_data   = krd1;
  assign if2.k_rd_data   = krd2;

  // All outputs of one instance packed:
  // kv, kd[8], v, bs, r1[8], r2[8], r3[8], busy, done, ire, kre, ia[8], ka[4]
  logic [50:0] pk0, pk1, pk2, obs;
  assign pk0 = {if0.o_kernel_valid, if0.o_kernel_data, if0.o_valid, if0.o_band_start,
                if0.o_row1_data, if0.o_row2_data, if0.o_row3_data, if0.busy, if0.done,
                if0.img_rd_en, if0.k_rd_en, if0.img_rd_addr, if0.k_rd_addr};
  assign pk1 = {if1.o_kernel_valid, if1.o_kernel_data, if1.o_valid, if1.o_band_start,
                if1.o_row1_data, if1.o_row2_data, if1.o_row3_data, if1.busy, if1.done,
                if1.img_rd_en, if1.k_rd_en, if1.img_rd_addr, if1.k_rd_addr};
  assign pk2 = {if2.o_kernel_valid, if2.o_kernel_data, if2.o_valid, if2.o_band_start,
                if2.o_row1_data, if2.o_row2_data, if2.o_row3_data, if2.busy, if2.done,
                if2.img_rd_en, if2.k_rd_en, if2.img_rd_addr, if2.k_rd_addr};
  always_comb begin
    obs = pk0;
    if (cur == 1) obs = pk1;
    if (cur == 2) obs = pk2;
  end

  logic        ob_kv, ob_v, ob_bs, ob_busy, ob_done, ob_ire, ob_kre;
  logic [7:0]  ob_kd, ob_r1, ob_r2, ob_r3;
  assign ob_kv   = obs[50];
  assign ob_kd   = obs[49:42];
  assign ob_v    = obs[41];
  assign ob_bs   = obs[40];
  assign ob_r1   = obs[39:32];
  assign ob_r2   = obs[31:24];
  assign ob_r3   = obs[23:16];
  assign ob_busy = obs[15];
  assign ob_done = obs[14];
  assign ob_ire  = obs[13];
  assign ob_kre  = obs[12];

  // Captured stream of the last pass and the reference stream.
  logic [7:0]  got_k[$];
  logic [24:0] got_col[$], exp_col[$], ref_col[$];
  int          done_cnt, done_cyc, busy_cnt, kfirst, klast, lastv_cyc, bs_cnt;
  bit          en_bad;
  logic [50:0] rst_obs;

  // Reference: walk the bands from the top; each column is the three
  // vertically adjacent pixels, flagged when it opens a band.
  function automatic void build_exp(input int w, input int h, input bit s);
    exp_col.delete();
    for (int rr = 0; rr + 2 <= h - 1; rr += (s ? 2 : 1))
      for (int cc = 0; cc < w; cc++)
        exp_col.push_back({cc == 0, img_mem[rr*w+cc], img_mem[(rr+1)*w+cc], img_mem[(rr+2)*w+cc]});
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 256; i++) img_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)  k_mem[i]   = 8'($urandom);
  endtask

  // Start one pass on instance `cur` and record everything it emits.
  // dist_at: re-pulse start with inverted stride; rst_at: pulse reset.
  task automatic run_pass(input bit s, input int dist_at, input int rst_at, input int budget);
    got_k.delete(); got_col.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; kfirst = -1; klast = -1;
    lastv_cyc = -1; bs_cnt = 0; en_bad = 0; rst_obs = '1;
    @(negedge clk); stride_d = s; start_d = 1'b1;
    @(posedge clk); #1; start_d = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc == dist_at)     begin start_d = 1'b1; stride_d = ~s; end
      if (cyc == dist_at + 3) begin start_d = 1'b0; stride_d = s; end
      if (cyc == rst_at) rst = 1'b1;
      @(negedge clk);
      if (cyc == rst_at) begin rst_obs = obs; rst = 1'b0; end
      if (ob_kv) begin got_k.push_back(ob_kd); if (kfirst < 0) kfirst = cyc; klast = cyc; end
      if (ob_v) begin got_col.push_back({ob_bs, ob_r1, ob_r2, ob_r3}); lastv_cyc = cyc; end
      if (ob_v && ob_bs) bs_cnt++;
      if (ob_busy) busy_cnt++;
      if (ob_done) begin done_cnt++; done_cyc = cyc; if (ob_ire || ob_kre) en_bad = 1; end
      if (!ob_busy && (ob_ire || ob_kre)) en_bad = 1;
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      @(negedge clk);
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_outputs inst%0d: got %h expected 0", i, obs); end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic_4x4();
    cur = 0; fill_random();
    for (int i = 0; i < 256; i++) img_mem[i] = 8'(i);
    run_pass(1'b0, -1, -1, 200);
    build_exp(4, 4, 1'b0);
    checks++; if (got_k.size() !== 9) begin errors++; $display("FAIL basic_kcount: got %0d expected 9", got_k.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (got_k[i] !== k_mem[i]) begin errors++; $display("FAIL basic_kword[%0d]: got %h expected %h", i, got_k[i], k_mem[i]); end
    end
    checks++; if (klast - kfirst !== 8) begin errors++; $display("FAIL basic_kcontig: got span %0d expected 8", klast - kfirst); end
    checks++; if (got_col.size() !== 8) begin errors++; $display("FAIL basic_ncols: got %0d expected 8", got_col.size()); end
    for (int i = 0; i < exp_col.size(); i++) begin
      checks++; if (got_col[i] !== exp_col[i]) begin errors++; $display("FAIL basic_col[%0d]: got %h expected %h", i, got_col[i], exp_col[i]); end
    end
    checks++; if (got_col[0] !== {1'b1, 8'd0, 8'd4, 8'd8}) begin errors++; $display("FAIL basic_col0_lit: got %h expected 1000408", got_col[0]); end
    checks++; if (got_col[4] !== {1'b1, 8'd4, 8'd8, 8'd12}) begin errors++; $display("FAIL basic_band1_lit: got %h expected 104080c", got_col[4]); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc !== 42) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 42", done_cyc); end
    checks++; if (busy_cnt !== 42) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 42", busy_cnt); end
    checks++; if (en_bad !== 1'b0) begin errors++; $display("FAIL basic_rd_en_idle: got 1 expected 0"); end
  endtask

  task automatic test_stride2();
    cur = 1; fill_random();
    run_pass(1'b1, -1, -1, 300);
    build_exp(5, 8, 1'b1);
    checks++; if (got_col.size() !== 15) begin errors++; $display("FAIL s2_ncols: got %0d expected 15", got_col.size()); end
    for (int i = 0; i < exp_col.size(); i++) begin
      checks++; if (got_col[i] !== exp_col[i]) begin errors++; $display("FAIL s2_col[%0d]: got %h expected %h", i, got_col[i], exp_col[i]); end
    end
    checks++; if (bs_cnt !== 3) begin errors++; $display("FAIL s2_band_starts: got %0d expected 3", bs_cnt); end
    for (int i = 0; i < 9; i++) begin
      checks++; if (got_k[i] !== k_mem[i]) begin errors++; $display("FAIL s2_kword[%0d]: got %h expected %h", i, got_k[i], k_mem[i]); end
    end
    checks++; if (done_cnt !== 1 || done_cyc !== 9 + 4*15 + 1) begin errors++; $display("FAIL s2_done: got cnt %0d cyc %0d expected 1 at %0d", done_cnt, done_cyc, 9 + 4*15 + 1); end
  endtask

  task automatic test_disturb();
    int cyc_ref;
    cur = 0; fill_random();
    run_pass(1'b0, -1, -1, 200);
    ref_col = got_col; cyc_ref = done_cyc;
    run_pass(1'b0, 15, -1, 200);
    build_exp(4, 4, 1'b0);
    checks++; if (got_col.size() !== ref_col.size()) begin errors++; $display("FAIL dist_ncols: got %0d expected %0d", got_col.size(), ref_col.size()); end
    for (int i = 0; i < exp_col.size(); i++) begin
      checks++; if (got_col[i] !== exp_col[i]) begin errors++; $display("FAIL dist_col[%0d]: got %h expected %h", i, got_col[i], exp_col[i]); end
      checks++; if (got_col[i] !== ref_col[i]) begin errors++; $display("FAIL dist_vs_clean[%0d]: got %h expected %h", i, got_col[i], ref_col[i]); end
    end
    checks++; if (done_cnt !== 1 || done_cyc !== cyc_ref) begin errors++; $display("FAIL dist_done: got cnt %0d cyc %0d expected 1 at %0d", done_cnt, done_cyc, cyc_ref); end
  endtask

  task automatic test_reset_mid();
    cur = 0; fill_random();
    // Band 1 first column starts phase 0 at cycle 26, so cycle 28 is phase 2.
    run_pass(1'b0, -1, 28, 50);
    checks++; if (rst_obs !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h expected 0", rst_obs); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
    checks++; if (got_col.size() !== 4) begin errors++; $display("FAIL rstmid_cols_before: got %0d expected 4", got_col.size()); end
    run_pass(1'b0, -1, -1, 200);
    build_exp(4, 4, 1'b0);
    checks++; if (got_k.size() !== 9) begin errors++; $display("FAIL rstmid_kcount: got %0d expected 9", got_k.size()); end
    checks++; if (got_col.size() !== 8) begin errors++; $display("FAIL rstmid_ncols: got %0d expected 8", got_col.size()); end
    for (int i = 0; i < exp_col.size(); i++) begin
      checks++; if (got_col[i] !== exp_col[i]) begin errors++; $display("FAIL rstmid_col[%0d]: got %h expected %h", i, got_col[i], exp_col[i]); end
    end
    checks++; if (done_cnt !== 1 || done_cyc !== 42) begin errors++; $display("FAIL rstmid_done: got cnt %0d cyc %0d expected 1 at 42", done_cnt, done_cyc); end
  endtask

  task automatic test_min_3x3();
    cur = 2;
    for (int s = 0; s < 2; s++) begin
      fill_random();
      run_pass(1'(s), -1, -1, 100);
      build_exp(3, 3, 1'(s));
      checks++; if (got_col.size() !== 3) begin errors++; $display("FAIL min_ncols s%0d: got %0d expected 3", s, got_col.size()); end
      for (int i = 0; i < exp_col.size(); i++) begin
        checks++; if (got_col[i] !== exp_col[i]) begin errors++; $display("FAIL min_col[%0d] s%0d: got %h expected %h", i, s, got_col[i], exp_col[i]); end
      end
      // done is visible in the same cycle as the final column's o_valid
      checks++; if (done_cnt !== 1 || done_cyc !== 22 || lastv_cyc !== done_cyc) begin
        errors++; $display("FAIL min_done s%0d: got cnt %0d cyc %0d lastv %0d expected 1 at 22", s, done_cnt, done_cyc, lastv_cyc);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cur = 0;
    start_d = 1'b0; stride_d = 1'b0; rst = 1'b0;
    test_reset();
    test_basic_4x4();
    test_stride2();
    test_disturb();
    test_reset_mid();
    test_min_3x3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, meaning pixel and kernel coefficient width.
REQ-002 SHALL have parameter IMG_W, default 8, meaning image width in pixels (>=3).
REQ-003 SHALL have parameter IMG_H, default 8, meaning image height in pixels (>=3).
REQ-004 SHALL have parameter ADDR_W, default 8, meaning image memory address width (2^ADDR_W >= IMG_W*IMG_H).
REQ-005 SHALL have port i_clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_rst, input, 1, meaning reset; it is asynchronous and active-high.
REQ-007 SHALL have port start, input, 1, meaning begin one frame pass; sampled only in IDLE.
REQ-008 SHALL have port stride, input, 1, meaning 0 gives row stride 1 and 1 gives row stride 2; latched on accepted start.
REQ-009 SHALL have port img_rd_addr, output, ADDR_W, meaning image memory read address.
REQ-010 SHALL have port img_rd_en, output, 1, meaning image memory read strobe.
REQ-011 SHALL have port img_rd_data, input, BIT_DEPTH, meaning image read data, valid one cycle after img_rd_en.
REQ-012 SHALL have port k_rd_addr, output, 4, meaning kernel memory read address 0..8.
REQ-013 SHALL have port k_rd_en, output, 1, meaning kernel memory read strobe.
REQ-014 SHALL have port k_rd_data, input, BIT_DEPTH, meaning kernel read data, valid one cycle after k_rd_en.
REQ-015 SHALL have port o_kernel_data, output, BIT_DEPTH, meaning kernel coefficient to the convolver.
REQ-016 SHALL have port o_kernel_valid, output, 1, meaning o_kernel_data is valid this cycle.
REQ-017 SHALL have ports o_row1_data, o_row2_data and o_row3_data, output, BIT_DEPTH each, meaning the pixel column at window rows r, r+1 and r+2.
REQ-018 SHALL have port o_valid, output, 1, meaning the o_rowN_data column is valid this cycle.
REQ-019 SHALL have port o_band_start, output, 1, meaning it marks the first column (c=0) of each band, coincident with o_valid.
REQ-020 SHALL have port busy, output, 1, meaning the block is not in IDLE.
REQ-021 SHALL have port done, output, 1, meaning a one-cycle pulse at frame-pass end.

Function
REQ-022 SHALL implement states IDLE, KERNEL, FETCH, DONE.
REQ-023 IDLE to KERNEL SHALL occur when start=1, latching stride and clearing r and c.
REQ-024 KERNEL SHALL issue k_rd_en for 9 consecutive cycles, addresses 0..8 in order.
REQ-025 Each kernel word SHALL appear on o_kernel_data with o_kernel_valid=1 one cycle after its read, giving 9 contiguous valid cycles.
REQ-026 KERNEL to FETCH SHALL occur on the cycle after the last kernel read, so the 9th o_kernel_valid overlaps FETCH phase 0.
REQ-027 FETCH SHALL use a 2-bit phase counter; phases 0, 1 and 2 assert img_rd_en with addresses r*IMG_W+c, (r+1)*IMG_W+c and (r+2)*IMG_W+c.
REQ-028 Phase 1 SHALL capture row r data, and phase 2 SHALL capture row r+1 data.
REQ-029 At the edge ending phase 3, the block SHALL load o_row1..3_data and pulse o_valid for one cycle, giving 4 cycles per column.
REQ-030 Column order SHALL be c=0..IMG_W-1, then r+=1 (stride=0) or r+=2 (stride=1), with c wrapping to 0.
REQ-031 The last band SHALL be the largest r with r+2 <= IMG_H-1; band count is IMG_H-2 for stride=0 and floor((IMG_H-3)/2)+1 for stride=1.
REQ-032 After phase 3 of the last column of the last band, the block SHALL enter DONE, pulse done for one cycle, then return to IDLE.
REQ-033 start SHALL be ignored in KERNEL, FETCH and DONE, and stride changes mid-pass SHALL have no effect.
REQ-034 Address arithmetic SHALL use full ADDR_W width without truncation for legal parameters.
REQ-035 img_rd_en and k_rd_en SHALL be 0 in IDLE and DONE.

Reset
REQ-036 While i_rst=1, the block SHALL force IDLE with all outputs 0, and r, c, phase and the latched stride cleared to 0.
REQ-037 Reset asserted mid-pass SHALL abort immediately with no done pulse, and the next start SHALL begin a fresh pass from KERNEL.

Verification
REQ-038 Scenario: IMG_W=IMG_H=4, stride=0, pixel = address -> 9 kernel valids, then 8 o_valid; band 0 columns are (0,4,8),(1,5,9),(2,6,10),(3,7,11); band 1 begins (4,8,12); done pulses once.
REQ-039 Scenario: IMG_H=8, stride=1 -> exactly 3 bands with r=0,2,4 and 3*IMG_W o_valid pulses; o_band_start is high 3 times.
REQ-040 Scenario: cycle count for 4x4, stride=0 from start accept to done -> 9 kernel cycles plus 8*4 FETCH cycles plus 1, with done at cycle 42 after start.
REQ-041 Scenario: start re-pulsed during FETCH and stride toggled -> no restart, and output sequence identical to an undisturbed pass.
REQ-042 Scenario: i_rst pulsed at phase 2 of band 1 -> all outputs 0 in that cycle, no done, and a subsequent start reproduces the full expected stream.
REQ-043 Scenario: IMG_W=IMG_H=3 -> single band of 3 columns, and done follows the 3rd o_valid.
